mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Single-port memory arbiter between the instruction-fetch path and the load/store path of the core.
- Grants one requester per access to a shared synchronous memory and sequences the access through a fixed read latency.
- Returns data or acknowledgements to the winning requester.
- Drops in-flight fetch data when a branch redirect kills the fetch.

Parameters:
XLEN, 32, data width of the memory and both requesters
ADDRLEN, 32, byte-address width
MEM_LAT, 1, cycles from mem_en to valid mem_rdata (1..7)
MAX_WAIT, 3, consecutive load/store grants allowed while a fetch is pending before fetch is forced to win (1..15)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
if_req  in  1  fetch request, held until if_gnt
if_addr  in  ADDRLEN  fetch address
if_kill  in  1  branch redirect: discard the pending fetch result
if_gnt  out  1  fetch granted this cycle
if_rvalid  out  1  one-cycle pulse, if_rdata valid
if_rdata  out  XLEN  fetched instruction
ls_req  in  1  load/store request, held until ls_gnt
ls_we  in  1  1 = store, 0 = load
ls_addr  in  ADDRLEN  data address
ls_wdata  in  XLEN  store data
ls_gnt  out  1  load/store granted this cycle
ls_rvalid  out  1  one-cycle pulse, load data or store ack
ls_rdata  out  XLEN  load data (0 on store ack)
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDRLEN  memory address
mem_wdata  out  XLEN  memory write data
mem_rdata  in  XLEN  memory read data, valid MEM_LAT cycles after mem_en
busy  out  1  access outstanding (state != IDLE)

Behaviour:
- Reset values: all outputs 0; state IDLE; wait counter 0; owner none; kill flag 0.
- States are IDLE, WAIT and RESP. Only one access is outstanding at a time.
- IDLE:
  - Arbitration is combinational.
  - If a request is present, assert exactly one gnt, plus mem_en, mem_addr and mem_we/mem_wdata from the winner, in the same cycle.
  - Latch the owner, then go to WAIT with latency counter = MEM_LAT-1.
- WAIT: decrement the counter each cycle; when the counter is 0, go to RESP.
- RESP:
  - Capture mem_rdata into the winner's rdata register and pulse its rvalid for one cycle.
  - Return to IDLE.
  - The next grant can occur in the cycle after RESP.
- Latency from gnt to rvalid is MEM_LAT+1 cycles.
- Stores:
  - mem_we=1 in the grant cycle only.
  - ls_rvalid still pulses in RESP, with ls_rdata=0.
- Priority:
  - Load/store wins over fetch, except when the starvation counter equals MAX_WAIT while if_req=1; then fetch wins.
  - Starvation counter increments on each ls grant while if_req=1, saturates at MAX_WAIT, and clears on any if grant or any cycle with if_req=0.
- Outside the grant cycle, mem_en=0 and mem_we=0. mem_addr and mem_wdata hold their last values.
- if_kill:
  - While a fetch is owned (WAIT/RESP, or the grant cycle itself), set the kill flag.
  - In RESP the fetch result is then discarded: if_rvalid stays 0 and if_rdata is unchanged. The kill flag clears on return to IDLE.
  - if_kill in IDLE without a grant has no effect.
  - if_kill never affects a load/store access.
- Simultaneous if_req and ls_req in IDLE: follow the priority rule; the loser waits with its request held.
- Reset mid-access: abort immediately to the reset state. No rvalid is produced for the aborted access, and no further mem_en occurs until a new grant.
- Request dropped before grant: legal; no access occurs.

Optional Feature:
ARB_PERF_CNT_EN
- Defined: add two 32-bit wrapping output counters, perf_if_stall and perf_ls_stall.
  - Each increments on every cycle its req=1 and its gnt=0.
  - Both clear on reset.
- Undefined: both ports are present and tied to 0, and no counter logic is built.

Test Plan:
- Reset, then if_req=1 with if_addr=0x10 and mem_rdata=0xDEADBEEF (MEM_LAT=1) -> if_gnt and mem_en in cycle 0; if_rvalid in cycle 2 with if_rdata=0xDEADBEEF.
- if_req and ls_req both 1 in the same cycle, ls load from 0x40 -> ls_gnt first; if_gnt in the cycle after ls_rvalid.
- Store: ls_we=1, ls_addr=0x80, ls_wdata=0x12345678 -> mem_we=1 for exactly one cycle, mem_wdata=0x12345678; ls_rvalid=1 two cycles later with ls_rdata=0.
- if_req held while ls_req is held continuously, MAX_WAIT=3 -> three ls grants, then the fourth grant goes to fetch; the counter clears afterwards.
- Fetch granted, if_kill pulsed in the WAIT/RESP window -> if_rvalid never asserts and if_rdata keeps its prior value; a subsequent fetch returns normally.
- reset asserted in WAIT during a load -> no ls_rvalid, busy=0 and all outputs 0 the next cycle. With ARB_PERF_CNT_EN defined, perf_if_stall counts the fetch wait cycles from the priority test (3×(MEM_LAT+2)=9 for MEM_LAT=1).

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter between fetch and load/store with fixed read latency.
// Optional ARB_PERF_CNT_EN builds the per-requester stall counters; otherwise those ports read 0.
module mem_arbiter #(
    parameter int XLEN     = 32,
    parameter int ADDRLEN  = 32,
    parameter int MEM_LAT  = 1,
    parameter int MAX_WAIT = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               if_req,
    input  logic [ADDRLEN-1:0] if_addr,
    input  logic               if_kill,
    output logic               if_gnt,
    output logic               if_rvalid,
    output logic [XLEN-1:0]    if_rdata,
    input  logic               ls_req,
    input  logic               ls_we,
    input  logic [ADDRLEN-1:0] ls_addr,
    input  logic [XLEN-1:0]    ls_wdata,
    output logic               ls_gnt,
    output logic               ls_rvalid,
    output logic [XLEN-1:0]    ls_rdata,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDRLEN-1:0] mem_addr,
    output logic [XLEN-1:0]    mem_wdata,
    input  logic [XLEN-1:0]    mem_rdata,
    output logic               busy,
    output logic [31:0]        perf_if_stall,
    output logic [31:0]        perf_ls_stall
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]         state;
    logic [2:0]         lat_cnt;
    logic [3:0]         starve_cnt;
    logic               owner_if, owner_ls, kill_q, we_q;
    logic [ADDRLEN-1:0] addr_q;
    logic [XLEN-1:0]    wdata_q, data_q, if_hold, ls_hold;
    logic               idle, if_win, ls_win;

    assign idle      = (state == IDLE) && !reset;
    assign if_win    = idle && if_req && (!ls_req || starve_cnt == 4'(MAX_WAIT));
    assign ls_win    = idle && ls_req && !if_win;
    assign if_gnt    = if_win;
    assign ls_gnt    = ls_win;
    assign mem_en    = if_win || ls_win;
    assign mem_we    = ls_win && ls_we;
    assign mem_addr  = if_win ? if_addr : ls_win ? ls_addr : addr_q;
    assign mem_wdata = ls_win ? ls_wdata : wdata_q;
    assign busy      = state != IDLE;
    // A kill arriving in the response cycle itself must still suppress delivery
    assign if_rvalid = !reset && state == RESP && owner_if && !(kill_q || if_kill);
    assign ls_rvalid = !reset && state == RESP && owner_ls;
    assign if_rdata  = if_rvalid ? data_q : if_hold;
    assign ls_rdata  = ls_rvalid ? (we_q ? '0 : data_q) : ls_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            owner_if   <= 1'b0;
            owner_ls   <= 1'b0;
            kill_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            data_q     <= '0;
            if_hold    <= '0;
            ls_hold    <= '0;
        end else begin
            addr_q     <= mem_addr;
            wdata_q    <= mem_wdata;
            starve_cnt <= (!if_req || if_win) ? '0 :
                          (ls_win && starve_cnt != 4'(MAX_WAIT)) ? starve_cnt + 4'd1 : starve_cnt;
            if (if_rvalid) if_hold <= data_q;
            if (ls_rvalid) ls_hold <= ls_rdata;
            case (state)
                IDLE: if (mem_en) begin
                    state    <= WAIT;
                    lat_cnt  <= 3'(MEM_LAT - 1);
                    owner_if <= if_win;
                    owner_ls <= ls_win;
                    we_q     <= mem_we;
                    kill_q   <= if_win && if_kill;
                end
                WAIT: begin
                    kill_q <= kill_q || (owner_if && if_kill);
                    if (lat_cnt == 3'd0) begin
                        state  <= RESP;
                        data_q <= mem_rdata;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    owner_if <= 1'b0;
                    owner_ls <= 1'b0;
                    kill_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_if_stall <= '0;
            perf_ls_stall <= '0;
        end else begin
            if (if_req && !if_gnt) perf_if_stall <= perf_if_stall + 32'd1;
            if (ls_req && !ls_gnt) perf_ls_stall <= perf_ls_stall + 32'd1;
        end
    end
`else
    assign perf_if_stall = '0;
    assign perf_ls_stall = '0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter with MEM_LAT=1, MAX_WAIT=3.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic if_req = 1'b0, if_kill = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
  logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0, mem_rdata = '0;
  logic if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we, busy;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata, perf_if_stall, perf_ls_stall;
  int passed = 0, total = 0;
  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy),
    .perf_if_stall(perf_if_stall), .perf_ls_stall(perf_ls_stall)
  );
  always #5 clk = ~clk;
  task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
    total++;
    if (o === e) passed++;
    else $error("FAIL %s got=%0h exp=%0h", t, o, e);
  endtask
  task automatic cyc;
    @(posedge clk);
    #2;
  endtask
  initial begin
    cyc; cyc; #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_perf", perf_if_stall | perf_ls_stall, 32'h0);
    reset = 1'b0;
    cyc;
    mem_rdata = 32'hDEADBEEF; if_req = 1'b1; if_addr = 32'h10; #1;
    chk("f_gnt", if_gnt, 1'b1);
    chk("f_mem_en", mem_en, 1'b1);
    chk("f_addr", mem_addr, 32'h10);
    chk("f_ls_gnt", ls_gnt, 1'b0);
    cyc; if_req = 1'b0; #1;
    chk("f_busy", busy, 1'b1);
    chk("f_en_off", mem_en, 1'b0);
    chk("f_addr_hold", mem_addr, 32'h10);
    chk("f_rv_early", if_rvalid, 1'b0);
    cyc; #1;
    chk("f_rvalid", if_rvalid, 1'b1);
    chk("f_rdata", if_rdata, 32'hDEADBEEF);
    cyc; #1;
    chk("f_rv_pulse", if_rvalid, 1'b0);
    chk("f_idle", busy, 1'b0);
    chk("f_rdata_hold", if_rdata, 32'hDEADBEEF);
    mem_rdata = 32'hCAFE0001; if_req = 1'b1; if_addr = 32'h20;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h40; #1;
    chk("p_ls_gnt", ls_gnt, 1'b1);
    chk("p_if_gnt", if_gnt, 1'b0);
    chk("p_addr", mem_addr, 32'h40);
    chk("p_we", mem_we, 1'b0);
    cyc; ls_req = 1'b0; #1;
    chk("p_if_wait", if_gnt, 1'b0);
    cyc; #1;
    chk("p_ls_rvalid", ls_rvalid, 1'b1);
    chk("p_ls_rdata", ls_rdata, 32'hCAFE0001);
    chk("p_if_wait2", if_gnt, 1'b0);
    cyc; #1;
    chk("p_if_gnt2", if_gnt, 1'b1);
    chk("p_if_addr", mem_addr, 32'h20);
    cyc; if_req = 1'b0; cyc; #1;
    chk("p_if_rdata", if_rdata, 32'hCAFE0001);
    cyc;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h80; ls_wdata = 32'h12345678; #1;
    chk("s_gnt", ls_gnt, 1'b1);
    chk("s_we", mem_we, 1'b1);
    chk("s_wdata", mem_wdata, 32'h12345678);
    cyc; ls_req = 1'b0; ls_we = 1'b0; #1;
    chk("s_we_off", mem_we, 1'b0);
    chk("s_wdata_hold", mem_wdata, 32'h12345678);
    cyc; #1;
    chk("s_rvalid", ls_rvalid, 1'b1);
    chk("s_rdata", ls_rdata, 32'h0);
    cyc;
    mem_rdata = 32'hA5A5A5A5; if_req = 1'b1; if_addr = 32'h24;
    ls_req = 1'b1; ls_addr = 32'h44; #1;
    for (int i = 0; i < 3; i++) begin
      chk("st_ls_gnt", ls_gnt, 1'b1);
      chk("st_if_held", if_gnt, 1'b0);
      cyc; cyc; cyc; #1;
    end
    chk("st_if_gnt", if_gnt, 1'b1);
    chk("st_ls_lose", ls_gnt, 1'b0);
    cyc; cyc; #1;
    chk("st_if_rvalid", if_rvalid, 1'b1);
    chk("st_if_rdata", if_rdata, 32'hA5A5A5A5);
    cyc; #1;
    chk("st_cnt_clr", ls_gnt, 1'b1);
    chk("st_cnt_clr_if", if_gnt, 1'b0);
    cyc; if_req = 1'b0; ls_req = 1'b0;
    cyc; cyc;
    mem_rdata = 32'h11111111; if_req = 1'b1; if_addr = 32'h30; #1;
    chk("k_gnt", if_gnt, 1'b1);
    cyc; if_req = 1'b0; if_kill = 1'b1; #1;
    chk("k_busy", busy, 1'b1);
    cyc; if_kill = 1'b0; #1;
    chk("k_no_rvalid", if_rvalid, 1'b0);
    chk("k_rdata_kept", if_rdata, 32'hA5A5A5A5);
    cyc;
    if_req = 1'b1; #1;
    chk("k2_gnt", if_gnt, 1'b1);
    cyc; if_req = 1'b0; cyc; if_kill = 1'b1; #1;
    chk("k2_no_rvalid", if_rvalid, 1'b0);
    chk("k2_rdata_kept", if_rdata, 32'hA5A5A5A5);
    cyc; #1;
    chk("k_idle_nognt", if_gnt, 1'b0);
    cyc; if_kill = 1'b0; mem_rdata = 32'h22222222; if_req = 1'b1; #1;
    chk("k3_gnt", if_gnt, 1'b1);
    cyc; if_req = 1'b0; cyc; #1;
    chk("k3_rvalid", if_rvalid, 1'b1);
    chk("k3_rdata", if_rdata, 32'h22222222);
    cyc;
    mem_rdata = 32'h33333333; ls_req = 1'b1; ls_addr = 32'h50; #1;
    chk("r_gnt", ls_gnt, 1'b1);
    cyc; ls_req = 1'b0; reset = 1'b1; #1;
    chk("r_rv_during", ls_rvalid, 1'b0);
    cyc; reset = 1'b0; #1;
    chk("r_busy", busy, 1'b0);
    chk("r_rvalid", ls_rvalid, 1'b0);
    chk("r_ls_rdata", ls_rdata, 32'h0);
    chk("r_if_rdata", if_rdata, 32'h0);
    chk("r_mem_addr", mem_addr, 32'h0);
    chk("r_mem_wdata", mem_wdata, 32'h0);
    cyc; #1;
    chk("r_rvalid2", ls_rvalid, 1'b0);
    chk("r_mem_en", mem_en, 1'b0);
    chk("r_perf", perf_if_stall | perf_ls_stall, 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
